calc_op_scheduler: RTL
======================

# calc_op_scheduler

Sequences one matrix operation from operator selection through ALU launch, sitting between the debounced confirm button, the mode/op/slot switches and `matrix_alu`. It latches the operator and operand slots, reads operand dimensions from the matrix store's metadata port, checks legality, then either starts the ALU or enters a timed error state. In that error state the user can re-confirm to retry early after fixing an operand.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz; sets the one-second prescaler.
- `ERR_SECONDS`, 10: error countdown length in seconds; legal range 1..15.
- `DIM_W`, 3: width of the row and column fields; legal dimensions are 1..5.
- `sys_clk_in`  in  1  system clock.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `enter_i`  in  1  single-cycle confirm pulse, qualified by calc mode.
- `op_sel_i`  in  3  operator switches: 000 add, 001 scalar-mul, 010 transpose, 011 matmul; 1xx is reserved.
- `slot_sel_i`  in  2  operand slot switches.
- `meta_slot_o`  out  2  metadata read address.
- `meta_valid_i`  in  1  slot populated; one-cycle read latency.
- `meta_rows_i`, `meta_cols_i`  in  DIM_W  each  slot dimensions; one-cycle read latency.
- `alu_start_o`  out  1  one-cycle ALU launch pulse.
- `alu_op_o`  out  3  latched operator.
- `alu_slot_a_o`, `alu_slot_b_o`  out  2 each  latched operand slots.
- `alu_done_i`  in  1  ALU completion pulse.
- `err_o`  out  1  high while in ERR.
- `err_code_o`  out  2  00 none, 01 dimension mismatch, 10 empty slot.
- `err_count_o`  out  4  seconds remaining; drives the "Err" countdown display.
- `busy_o`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, SEL_OP, SEL_A, SEL_B, FETCH_A, FETCH_B, CHECK, RUN, ERR.
- IDLE: on `enter_i`, go to SEL_OP.
- SEL_OP: on `enter_i`, behaviour depends on `op_sel_i`.
  - Reserved code (1xx): ignored; stay in SEL_OP.
  - Otherwise: latch `op_sel_i` and go to SEL_A.
- SEL_A: on `enter_i`, latch the slot into A.
  - Unary op (scalar-mul, transpose): go to FETCH_A.
  - Otherwise: go to SEL_B.
- SEL_B: on `enter_i`, latch the slot into B and go to FETCH_A.
- FETCH_A: drive `meta_slot_o`=A and capture the metadata on the following cycle. Then go to FETCH_B for binary ops, or CHECK for unary ops.
- FETCH_B: same two-cycle read for slot B, then go to CHECK.
- CHECK (one cycle): evaluate legality in this order.
  - Any operand with `meta_valid_i`=0: code 10.
  - Add with unequal rows or cols: code 01.
  - Matmul with colsA != rowsB: code 01.
  - Legal: pulse `alu_start_o` and go to RUN.
  - Illegal: go to ERR and load `err_count_o`=ERR_SECONDS.
- RUN: wait for `alu_done_i`, then go to IDLE.
- ERR: `err_count_o` decrements on each one-second tick.
  - Tick while the count is 1: count goes to 0, `err_code_o` clears, go to IDLE.
  - `enter_i` (early retry): go to FETCH_A with the op and slots unchanged, restart the prescaler, clear `err_code_o`.
- `enter_i` is ignored in FETCH_A, FETCH_B, CHECK and RUN.
- `alu_done_i` is ignored outside RUN.
- `alu_op_o` and the slot outputs hold their latched values until the next latch.

## Timing
- Reset values:
  - State IDLE.
  - `alu_start_o`, `err_o`, `busy_o` = 0.
  - `err_code_o`, `err_count_o`, `meta_slot_o`, `alu_op_o` = 0.
  - `alu_slot_a_o`=0, `alu_slot_b_o`=1.
- Reset mid-RUN returns to IDLE. This block does not abort the ALU.
- All outputs are registered.
- Launch latency, measured from the final `enter_i`:
  - Binary op: 6 cycles to `alu_start_o`.
  - Unary op: 4 cycles to `alu_start_o`.
- Prescaler counts 0..CLK_FREQ-1. It resets on ERR entry and on retry, and its tick fires on the terminal count.
- Tick and `enter_i` in the same cycle: retry wins.

## Configuration
- `CALC_SLOT_SEL_EN` defined: SEL_A and SEL_B are present as described.
- `CALC_SLOT_SEL_EN` undefined:
  - Slots are fixed at A=0 and B=1.
  - SEL_OP goes directly to FETCH_A.
  - `slot_sel_i` is unused.
  - Binary-op launch latency becomes 6 cycles after the op confirm.

## Structure
- Package `calc_pkg` holds:
  - op code constants;
  - the state encoding;
  - error code constants;
  - helper function `is_unary(op)`.
- Sub-module `err_countdown` contains the prescaler and the 4-bit down-counter, with `load`, `clear`, `tick` and `expired` signals.

## Test plan
- Add, A=2x3, B=2x3, slots 0/1: `alu_start_o` pulses once, 6 cycles after the B confirm, with `alu_op_o`=000.
- Add, A=2x3, B=2x2: `err_o`=1 and code 01. With a reduced CLK_FREQ, count steps 10→9→…→0, then IDLE and `err_o`=0.
- Matmul, A=2x3, B=3x2: start pulse. Matmul, A=2x3, B=2x3: code 01.
- Transpose on an empty slot 2: code 10. Neither SEL_B nor FETCH_B is visited.
- ERR with count 7; fix the B metadata to 2x3; pulse `enter_i`: refetch, start pulse, `err_code_o`=00.
- Assert reset during RUN and during ERR: all outputs take their reset values immediately. A later `alu_done_i` in IDLE is ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared op codes, state encoding and error codes for the calc scheduler
//
// Purpose: constants and helpers imported by calc_op_scheduler, its interface
// and err_countdown. No ports.

package calc_pkg;

   // Operator switch codes; any code with bit 2 set is reserved.
   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_SMUL   = 3'b001;
   localparam logic [2:0] OP_TRANS  = 3'b010;
   localparam logic [2:0] OP_MATMUL = 3'b011;

   // Error codes shown alongside the "Err" countdown.
   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_DIM   = 2'b01;
   localparam logic [1:0] ERR_EMPTY = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEL_OP,
      ST_SEL_A,
      ST_SEL_B,
      ST_FETCH_A,
      ST_FETCH_B,
      ST_CHECK,
      ST_RUN,
      ST_ERR
   } state_t;

   // Unary ops take only operand A; B is neither selected nor fetched.
   function automatic logic is_unary(input logic [2:0] op);
      return (op == OP_SMUL) || (op == OP_TRANS);
   endfunction

endpackage

// File: rtl/calc_op_scheduler_if.sv
// rtl/calc_op_scheduler_if.sv - metadata read port and ALU launch handshake
//
// Purpose: bundles the scheduler's matrix-store metadata port and the
// matrix_alu launch/done handshake.
//   meta_slot_o              metadata read address (scheduler -> store)
//   meta_valid_i             slot populated, one-cycle read latency
//   meta_rows_i/meta_cols_i  slot dimensions, one-cycle read latency
//   alu_start_o              one-cycle ALU launch pulse
//   alu_op_o                 latched operator
//   alu_slot_a_o/b_o         latched operand slots
//   alu_done_i               ALU completion pulse
// Modports: master = scheduler side, slave = store/ALU side.

interface calc_op_scheduler_if #(
   parameter int DIM_W = 3
);
   logic [1:0]       meta_slot_o;
   logic             meta_valid_i;
   logic [DIM_W-1:0] meta_rows_i;
   logic [DIM_W-1:0] meta_cols_i;
   logic             alu_start_o;
   logic [2:0]       alu_op_o;
   logic [1:0]       alu_slot_a_o;
   logic [1:0]       alu_slot_b_o;
   logic             alu_done_i;

   modport master (
      output meta_slot_o, alu_start_o, alu_op_o, alu_slot_a_o, alu_slot_b_o,
      input  meta_valid_i, meta_rows_i, meta_cols_i, alu_done_i
   );

   modport slave (
      input  meta_slot_o, alu_start_o, alu_op_o, alu_slot_a_o, alu_slot_b_o,
      output meta_valid_i, meta_rows_i, meta_cols_i, alu_done_i
   );
endinterface

// File: rtl/err_countdown.sv
// rtl/err_countdown.sv - one-second prescaler and 4-bit error countdown
//
// Purpose: counts down from ERR_SECONDS once per second while active.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        start a countdown: count = ERR_SECONDS, prescaler restarted
//   clear       abandon the countdown: count = 0, prescaler restarted, idle
//   tick        one-second strobe (prescaler terminal count while active)
//   expired     the tick that takes the count from 1 to 0
//   count       seconds remaining (registered)

module err_countdown #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int ERR_SECONDS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       clear,
   output logic       tick,
   output logic       expired,
   output logic [3:0] count
);

   localparam int PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);

   logic [PRE_W-1:0] pre;
   logic             active;

   assign tick    = active && (pre == PRE_LAST);
   assign expired = tick && (count == 4'd1);

   // clear beats load beats counting, so a retry in the same cycle as a
   // tick never lets the tick through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre    <= '0;
         count  <= 4'd0;
         active <= 1'b0;
      end else if (clear) begin
         pre    <= '0;
         count  <= 4'd0;
         active <= 1'b0;
      end else if (load) begin
         pre    <= '0;
         count  <= 4'(ERR_SECONDS);
         active <= 1'b1;
      end else if (active) begin
         if (tick) begin
            pre   <= '0;
            count <= count - 4'd1;
            if (count == 4'd1) begin
               active <= 1'b0;
            end
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end

endmodule

// File: rtl/calc_op_scheduler.sv
// rtl/calc_op_scheduler.sv - sequences one matrix op from operator select to ALU launch
//
// Purpose: latches operator and operand slots from the switches on each
// confirm, fetches operand metadata, checks legality, then launches the ALU
// or holds a timed error that the user can retry early.
// Ports:
//   sys_clk_in, sys_rst_n  clock, asynchronous active-low reset
//   enter_i                single-cycle confirm pulse
//   op_sel_i               operator switches (1xx reserved)
//   slot_sel_i             operand slot switches
//   bus                    metadata read port + ALU handshake (master)
//   err_o, err_code_o      error flag and code (01 dims, 10 empty slot)
//   err_count_o            seconds remaining in the error display
//   busy_o                 high whenever not idle
// Build option: CALC_SLOT_SEL_EN enables the slot-select steps; without it
// the operands are fixed to slots 0 and 1 and slot_sel_i is unused.

module calc_op_scheduler
   import calc_pkg::*;
#(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int ERR_SECONDS = 10,
   parameter int DIM_W       = 3
) (
   input  logic                sys_clk_in,
   input  logic                sys_rst_n,
   input  logic                enter_i,
   input  logic [2:0]          op_sel_i,
   input  logic [1:0]          slot_sel_i,
   calc_op_scheduler_if.master bus,
   output logic                err_o,
   output logic [1:0]          err_code_o,
   output logic [3:0]          err_count_o,
   output logic                busy_o
);

   state_t           state;
   logic             fetch_phase;   // 0: address presented, 1: data on the bus
   logic [2:0]       op_q;
   logic [1:0]       slot_a_q;
   logic [1:0]       slot_b_q;
   logic [1:0]       meta_slot_q;
   logic             start_q;
   logic             valid_a_q;
   logic             valid_b_q;
   logic [DIM_W-1:0] rows_a_q;
   logic [DIM_W-1:0] cols_a_q;
   logic [DIM_W-1:0] rows_b_q;
   logic [DIM_W-1:0] cols_b_q;
   logic [1:0]       chk_code;

   logic cd_load;
   logic cd_clear;
   logic cd_expired;
   logic unused_cd_tick;

`ifndef CALC_SLOT_SEL_EN
   logic unused_slot_sel;
   assign unused_slot_sel = ^slot_sel_i;
`endif

   assign bus.meta_slot_o  = meta_slot_q;
   assign bus.alu_start_o  = start_q;
   assign bus.alu_op_o     = op_q;
   assign bus.alu_slot_a_o = slot_a_q;
   assign bus.alu_slot_b_o = slot_b_q;

   // Legality, in priority order: empty operand, then dimension rules.
   // B's captured metadata is stale for unary ops and is not consulted.
   always_comb begin
      chk_code = ERR_NONE;
      if (!valid_a_q || (!is_unary(op_q) && !valid_b_q)) begin
         chk_code = ERR_EMPTY;
      end else if (op_q == OP_ADD && (rows_a_q != rows_b_q || cols_a_q != cols_b_q)) begin
         chk_code = ERR_DIM;
      end else if (op_q == OP_MATMUL && cols_a_q != rows_b_q) begin
         chk_code = ERR_DIM;
      end
   end

   assign cd_load  = (state == ST_CHECK) && (chk_code != ERR_NONE);
   assign cd_clear = (state == ST_ERR) && enter_i;

   err_countdown #(
      .CLK_FREQ    (CLK_FREQ),
      .ERR_SECONDS (ERR_SECONDS)
   ) u_countdown (
      .clk     (sys_clk_in),
      .rst_n   (sys_rst_n),
      .load    (cd_load),
      .clear   (cd_clear),
      .tick    (unused_cd_tick),
      .expired (cd_expired),
      .count   (err_count_o)
   );

   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= ST_IDLE;
         fetch_phase <= 1'b0;
         op_q        <= 3'b000;
         slot_a_q    <= 2'd0;
         slot_b_q    <= 2'd1;
         meta_slot_q <= 2'd0;
         start_q     <= 1'b0;
         valid_a_q   <= 1'b0;
         valid_b_q   <= 1'b0;
         rows_a_q    <= '0;
         cols_a_q    <= '0;
         rows_b_q    <= '0;
         cols_b_q    <= '0;
         err_o       <= 1'b0;
         err_code_o  <= ERR_NONE;
         busy_o      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enter_i) begin
                  state  <= ST_SEL_OP;
                  busy_o <= 1'b1;
               end
            end

            ST_SEL_OP: begin
               if (enter_i && !op_sel_i[2]) begin
                  op_q <= op_sel_i;
`ifdef CALC_SLOT_SEL_EN
                  state <= ST_SEL_A;
`else
                  state       <= ST_FETCH_A;
                  fetch_phase <= 1'b0;
                  meta_slot_q <= slot_a_q;
`endif
               end
            end

`ifdef CALC_SLOT_SEL_EN
            ST_SEL_A: begin
               if (enter_i) begin
                  slot_a_q <= slot_sel_i;
                  if (is_unary(op_q)) begin
                     state       <= ST_FETCH_A;
                     fetch_phase <= 1'b0;
                     // slot_a_q is updating this same edge; address from the switches.
                     meta_slot_q <= slot_sel_i;
                  end else begin
                     state <= ST_SEL_B;
                  end
               end
            end

            ST_SEL_B: begin
               if (enter_i) begin
                  slot_b_q    <= slot_sel_i;
                  state       <= ST_FETCH_A;
                  fetch_phase <= 1'b0;
                  meta_slot_q <= slot_a_q;
               end
            end
`endif

            ST_FETCH_A: begin
               fetch_phase <= ~fetch_phase;
               if (fetch_phase) begin
                  valid_a_q <= bus.meta_valid_i;
                  rows_a_q  <= bus.meta_rows_i;
                  cols_a_q  <= bus.meta_cols_i;
                  if (is_unary(op_q)) begin
                     state <= ST_CHECK;
                  end else begin
                     state       <= ST_FETCH_B;
                     meta_slot_q <= slot_b_q;
                  end
               end
            end

            ST_FETCH_B: begin
               fetch_phase <= ~fetch_phase;
               if (fetch_phase) begin
                  valid_b_q <= bus.meta_valid_i;
                  rows_b_q  <= bus.meta_rows_i;
                  cols_b_q  <= bus.meta_cols_i;
                  state     <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (chk_code == ERR_NONE) begin
                  start_q <= 1'b1;
                  state   <= ST_RUN;
               end else begin
                  state      <= ST_ERR;
                  err_o      <= 1'b1;
                  err_code_o <= chk_code;
               end
            end

            ST_RUN: begin
               if (bus.alu_done_i) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
            end

            ST_ERR: begin
               // Retry wins over a coincident final tick.
               if (enter_i) begin
                  state       <= ST_FETCH_A;
                  fetch_phase <= 1'b0;
                  meta_slot_q <= slot_a_q;
                  err_o       <= 1'b0;
                  err_code_o  <= ERR_NONE;
               end else if (cd_expired) begin
                  state      <= ST_IDLE;
                  err_o      <= 1'b0;
                  err_code_o <= ERR_NONE;
                  busy_o     <= 1'b0;
               end
            end

            default: begin
               state      <= ST_IDLE;
               err_o      <= 1'b0;
               err_code_o <= ERR_NONE;
               busy_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule
